// File: rtl/hline_pkg.sv
// Shared definitions for the horizontal-span setup block and its divider.
package hline_pkg;

  // Pixel coordinate width and the divisor width needed to hold dx (1..2048).
  localparam int COORD_W         = 11;
  localparam int DIVISOR_W       = COORD_W + 1;
  localparam int DIV_CYCLES      = 32;
  localparam int CNT_W           = $clog2(DIV_CYCLES + 1);
  localparam int BYTES_PER_PIXEL = 4;

  // Controller state encoding, visible on the debug state output.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SETUP   = 4'd1,
    ST_DIV     = 4'd2,
    ST_FIX     = 4'd3,
    ST_ISSUE   = 4'd4,
    ST_WAIT_LO = 4'd5,
    ST_WAIT_HI = 4'd6,
    ST_DONE    = 4'd7
  } state_t;

  // Byte address of pixel (x, y) in a surface whose pitch is 2^stride_log2 bytes.
  function automatic logic [31:0] pixel_addr(input logic [31:0]        base,
                                             input logic [COORD_W-1:0] y,
                                             input logic [3:0]         stride_log2,
                                             input logic [COORD_W-1:0] x);
    logic [31:0] row_off;
    logic [31:0] col_off;
    row_off = 32'(y) << stride_log2;
    col_off = 32'(x) * 32'(BYTES_PER_PIXEL);
    return base + row_off + col_off;
  endfunction

endpackage

// File: rtl/hline_div.sv
// Unsigned restoring divider: 32-bit dividend by 12-bit divisor, one quotient
// bit per cycle. i_start loads the operands; o_busy is high for exactly
// DIV_CYCLES cycles afterwards; o_valid rises when the last bit is resolved
// and stays high until the next i_start.
module hline_div
  import hline_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [31:0]          i_dividend,
  input  logic [DIVISOR_W-1:0] i_divisor,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic [31:0]          o_quotient,
  output logic [DIVISOR_W-1:0] o_remainder
);

  logic [31:0]          r_quo;
  logic [DIVISOR_W-1:0] r_rem;
  logic [DIVISOR_W-1:0] r_div;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_valid;

  logic [DIVISOR_W:0]   w_partial;
  logic [DIVISOR_W:0]   w_trial;
  logic                 w_fits;

  // Bring the next dividend bit into the partial remainder and try a subtract.
  // The partial remainder is always below 2*divisor, so the top bit of the
  // trial difference is a reliable borrow flag.
  always_comb begin
    w_partial = {r_rem, r_quo[31]};
    w_trial   = w_partial - {1'b0, r_div};
    w_fits    = ~w_trial[DIVISOR_W];
  end

  // Operand load on start, then one restoring step per cycle while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_start) begin
      r_quo   <= i_dividend;
      r_rem   <= '0;
      r_div   <= i_divisor;
      r_cnt   <= CNT_W'(DIV_CYCLES);
      r_valid <= 1'b0;
    end else if (r_cnt != '0) begin
      r_quo <= {r_quo[30:0], w_fits};
      r_rem <= w_fits ? w_trial[DIVISOR_W-1:0] : w_partial[DIVISOR_W-1:0];
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) begin
        r_valid <= 1'b1;
      end
    end
  end

  assign o_busy      = (r_cnt != '0);
  assign o_valid     = r_valid;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/hline_setup.sv
// Span setup for a z-buffered horizontal line: orders the endpoints, forms the
// pixel count, framebuffer and z-buffer addresses, and the per-pixel depth
// slope/remainder, then hands the span to the downstream engine and waits for
// it to finish.
//
// Downstream handshake: hl_start is a one-cycle request pulse. hl_done is a
// level; a high level left over from the previous span is ignored until
// hl_done has been seen low once, and the next rising level completes the span.
module hline_setup
  import hline_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y,
  input  logic [31:0]        z1,
  input  logic [31:0]        z2,
  input  logic [31:0]        fb_base,
  input  logic [31:0]        zbuff_base,
  input  logic [3:0]         stride_log2,
  input  logic               hl_done,
  output logic               hl_start,
  output logic [31:0]        fb_addr,
  output logic [31:0]        zbuff_addr,
  output logic [31:0]        dx,
  output logic [31:0]        slope,
  output logic [31:0]        z_start,
  output logic [31:0]        rem,
  output logic [31:0]        err,
  output logic               busy,
  output logic               done,
  output state_t             dbg_state
);

  state_t               r_state;
  state_t               w_state_next;

  // Request captured in IDLE.
  logic [COORD_W-1:0]   r_x1;
  logic [COORD_W-1:0]   r_x2;
  logic [COORD_W-1:0]   r_y;
  logic [31:0]          r_z1;
  logic [31:0]          r_z2;
  logic [31:0]          r_fb_base;
  logic [31:0]          r_zb_base;
  logic [3:0]           r_stride;

  // Working state and registered span parameters.
  logic                 r_neg;
  logic [CNT_W-1:0]     r_cnt;
  logic [31:0]          r_fb_addr;
  logic [31:0]          r_zb_addr;
  logic [31:0]          r_dx;
  logic [31:0]          r_slope;
  logic [31:0]          r_z_start;
  logic [31:0]          r_rem;
  logic                 r_hl_start;
  logic                 r_busy;
  logic                 r_done;

  // Ordered endpoints and derived quantities, valid while in SETUP.
  logic                 w_swap;
  logic [COORD_W-1:0]   w_xa;
  logic [COORD_W-1:0]   w_xb;
  logic [31:0]          w_za;
  logic [31:0]          w_zb;
  logic [DIVISOR_W-1:0] w_dx;
  logic [31:0]          w_dz;
  logic [31:0]          w_mag;

  logic                 w_div_start;
  logic                 w_div_busy;
  logic                 w_div_valid;
  logic [31:0]          w_quo;
  logic [DIVISOR_W-1:0] w_rem;

  // Put the span in left-to-right order and take the depth delta's magnitude;
  // the divider works unsigned and the sign is reapplied in FIX.
  always_comb begin
    w_swap = (r_x2 < r_x1);
    w_xa   = w_swap ? r_x2 : r_x1;
    w_xb   = w_swap ? r_x1 : r_x2;
    w_za   = w_swap ? r_z2 : r_z1;
    w_zb   = w_swap ? r_z1 : r_z2;
    w_dx   = {1'b0, w_xb} - {1'b0, w_xa} + DIVISOR_W'(1);
    w_dz   = w_zb - w_za;
    w_mag  = w_dz[31] ? (32'd0 - w_dz) : w_dz;
  end

  assign w_div_start = (r_state == ST_SETUP);

  hline_div u_div (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_div_start),
    .i_dividend  (w_mag),
    .i_divisor   (w_dx),
    .o_busy      (w_div_busy),
    .o_valid     (w_div_valid),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode. DIV length is paced by the local counter; FIX also
  // requires the divider to report a finished result.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:    if (start) w_state_next = ST_SETUP;
      ST_SETUP:   w_state_next = ST_DIV;
      ST_DIV:     if (r_cnt == '0) w_state_next = ST_FIX;
      ST_FIX:     if (w_div_valid && !w_div_busy) w_state_next = ST_ISSUE;
      ST_ISSUE:   w_state_next = ST_WAIT_LO;
      ST_WAIT_LO: if (!hl_done) w_state_next = ST_WAIT_HI;
      ST_WAIT_HI: if (hl_done) w_state_next = ST_DONE;
      ST_DONE:    w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // Capture the request when a span is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x1      <= '0;
      r_x2      <= '0;
      r_y       <= '0;
      r_z1      <= '0;
      r_z2      <= '0;
      r_fb_base <= '0;
      r_zb_base <= '0;
      r_stride  <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_x1      <= x1;
      r_x2      <= x2;
      r_y       <= y;
      r_z1      <= z1;
      r_z2      <= z2;
      r_fb_base <= fb_base;
      r_zb_base <= zbuff_base;
      r_stride  <= stride_log2;
    end
  end

  // SETUP results: addresses, pixel count, start depth, slope sign, DIV pacing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fb_addr <= '0;
      r_zb_addr <= '0;
      r_dx      <= '0;
      r_z_start <= '0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
    end else if (r_state == ST_SETUP) begin
      r_fb_addr <= pixel_addr(r_fb_base, r_y, r_stride, w_xa);
      r_zb_addr <= pixel_addr(r_zb_base, r_y, r_stride, w_xa);
      r_dx      <= 32'(w_dx);
      r_z_start <= w_za;
      r_neg     <= w_dz[31];
      r_cnt     <= CNT_W'(DIV_CYCLES - 1);
    end else if (r_state == ST_DIV && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // FIX: apply the depth sign to the quotient (truncation toward zero) and
  // publish the unsigned remainder.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slope <= '0;
      r_rem   <= '0;
    end else if (r_state == ST_FIX) begin
      r_slope <= r_neg ? (32'd0 - w_quo) : w_quo;
      r_rem   <= 32'(w_rem);
    end
  end

  // Registered strobes and status, decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hl_start <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_hl_start <= (w_state_next == ST_ISSUE);
      r_busy     <= (w_state_next != ST_IDLE);
      r_done     <= (w_state_next == ST_DONE);
    end
  end

  assign hl_start   = r_hl_start;
  assign fb_addr    = r_fb_addr;
  assign zbuff_addr = r_zb_addr;
  assign dx         = r_dx;
  assign slope      = r_slope;
  assign z_start    = r_z_start;
  assign rem        = r_rem;
  // The downstream stepper always begins a span with zero accumulated error.
  assign err        = 32'd0;
  assign busy       = r_busy;
  assign done       = r_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_hline_setup.sv
// Bench for hline_setup: directed spans, randomized spans, downstream
// handshake timing and mid-divide reset.
module tb_hline_setup;
  import hline_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] x1 = '0, x2 = '0, y = '0;
  logic [31:0] z1 = '0, z2 = '0, fb_base = '0, zbuff_base = '0;
  logic [3:0]  stride_log2 = '0;
  logic        hl_done = 1'b1;

  logic        hl_start, busy, done;
  logic [31:0] fb_addr, zbuff_addr, dx, slope, z_start, rem, err;
  state_t      dbg_state;

  int total = 0;
  int bad   = 0;

  // Values observed at hl_start of the most recent span.
  logic [31:0] cap_dx, cap_slope, cap_rem, cap_fb, cap_zb, cap_zs;

  hline_setup dut (
    .clk(clk), .reset(reset), .start(start),
    .x1(x1), .x2(x2), .y(y), .z1(z1), .z2(z2),
    .fb_base(fb_base), .zbuff_base(zbuff_base), .stride_log2(stride_log2),
    .hl_done(hl_done), .hl_start(hl_start),
    .fb_addr(fb_addr), .zbuff_addr(zbuff_addr), .dx(dx), .slope(slope),
    .z_start(z_start), .rem(rem), .err(err),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: span parameters straight from the arithmetic definition.
  task automatic model(input logic [10:0] a_x1, a_x2, a_y,
                       input logic [31:0] a_z1, a_z2, a_fb, a_zb,
                       input logic [3:0] a_sl,
                       output logic [31:0] e_dx, e_sl, e_rem, e_zs, e_fb, e_zba);
    logic [31:0] xa, xb, za, zb, dz, row;
    logic [63:0] mag, q, r;
    if (a_x2 < a_x1) begin
      xa = 32'(a_x2); xb = 32'(a_x1); za = a_z2; zb = a_z1;
    end else begin
      xa = 32'(a_x1); xb = 32'(a_x2); za = a_z1; zb = a_z2;
    end
    e_dx = xb - xa + 1;
    dz   = zb - za;
    mag  = ($signed(dz) < 0) ? (64'h1_0000_0000 - {32'd0, dz}) : {32'd0, dz};
    q    = mag / {32'd0, e_dx};
    r    = mag % {32'd0, e_dx};
    e_sl  = ($signed(dz) < 0) ? (32'd0 - q[31:0]) : q[31:0];
    e_rem = r[31:0];
    e_zs  = za;
    row   = 32'(a_y) << a_sl;
    e_fb  = a_fb + row + xa * 4;
    e_zba = a_zb + row + xa * 4;
  endtask

  // One complete span: request, issue timing, parameters, handshake, done pulse.
  task automatic run_span(input string name,
                          input logic [10:0] a_x1, a_x2, a_y,
                          input logic [31:0] a_z1, a_z2, a_fb, a_zb,
                          input logic [3:0] a_sl,
                          input int drop_d, input int rise_d);
    logic [31:0] e_dx, e_sl, e_rem, e_zs, e_fb, e_zba;
    int cyc;
    int extra_pulses;
    model(a_x1, a_x2, a_y, a_z1, a_z2, a_fb, a_zb, a_sl, e_dx, e_sl, e_rem, e_zs, e_fb, e_zba);
    @(negedge clk);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({name, "_idle_done"}, 32'(done), 32'd0);
    x1 = a_x1; x2 = a_x2; y = a_y; z1 = a_z1; z2 = a_z2;
    fb_base = a_fb; zbuff_base = a_zb; stride_log2 = a_sl;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk({name, "_busy"}, 32'(busy), 32'd1);
    while (hl_start !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      // A second request while busy must not disturb the span in flight.
      if (cyc == 10) begin start = 1'b1; x1 = ~a_x1; z1 = ~a_z1; fb_base = ~a_fb; end
      if (cyc == 11) start = 1'b0;
    end
    start = 1'b0;
    chk({name, "_hl_start_cycle"}, 32'(cyc), 32'd35);
    cap_dx = dx; cap_slope = slope; cap_rem = rem;
    cap_fb = fb_addr; cap_zb = zbuff_addr; cap_zs = z_start;
    chk({name, "_dx"}, dx, e_dx);
    chk({name, "_slope"}, slope, e_sl);
    chk({name, "_rem"}, rem, e_rem);
    chk({name, "_z_start"}, z_start, e_zs);
    chk({name, "_fb_addr"}, fb_addr, e_fb);
    chk({name, "_zbuff_addr"}, zbuff_addr, e_zba);
    chk({name, "_err"}, err, 32'd0);
    extra_pulses = 0;
    for (int i = 0; i < drop_d; i++) begin
      @(negedge clk);
      if (hl_start === 1'b1) extra_pulses++;
      if (done === 1'b1) extra_pulses++;
    end
    hl_done = 1'b0;
    for (int i = 0; i < rise_d; i++) begin
      @(negedge clk);
      if (hl_start === 1'b1) extra_pulses++;
      if (done === 1'b1) extra_pulses++;
    end
    chk({name, "_wait_busy"}, 32'(busy), 32'd1);
    hl_done = 1'b1;
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(done), 32'd1);
    chk({name, "_stray_pulses"}, 32'(extra_pulses), 32'd0);
    chk({name, "_slope_hold"}, slope, e_sl);
    chk({name, "_fb_hold"}, fb_addr, e_fb);
  endtask

  // Reset during the 20th DIV cycle, then confirm nothing is issued.
  task automatic reset_mid_div();
    int cyc;
    int pulses;
    @(negedge clk);
    x1 = 11'd3; x2 = 11'd700; y = 11'd9; z1 = 32'd5; z2 = 32'd123456;
    fb_base = 32'h4000_0000; zbuff_base = 32'h5000_0000; stride_log2 = 4'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 21) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    #1;
    chk("rst_div_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_div_busy", 32'(busy), 32'd0);
    chk("rst_div_hl_start", 32'(hl_start), 32'd0);
    chk("rst_div_done", 32'(done), 32'd0);
    chk("rst_div_dx", dx, 32'd0);
    chk("rst_div_slope", slope, 32'd0);
    chk("rst_div_fb", fb_addr, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (hl_start === 1'b1 || done === 1'b1 || busy === 1'b1) pulses++;
    end
    chk("rst_div_quiet", 32'(pulses), 32'd0);
  endtask

  initial begin
    logic [10:0] rx1, rx2, ry;
    // Reset state
    @(negedge clk);
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("reset_hl_start", 32'(hl_start), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_fb_addr", fb_addr, 32'd0);
    chk("reset_slope", slope, 32'd0);
    reset = 1'b0;

    // Basic span, with the downstream engine's done timing from the handshake case.
    run_span("basic", 11'd10, 11'd19, 11'd2, 32'd100, 32'd200,
             32'h1000_0000, 32'h2000_0000, 4'd12, 2, 50);
    chk("basic_dx_const", cap_dx, 32'd10);
    chk("basic_slope_const", cap_slope, 32'd10);
    chk("basic_rem_const", cap_rem, 32'd0);
    chk("basic_fb_const", cap_fb, 32'h1000_2028);
    chk("basic_zb_const", cap_zb, 32'h2000_2028);

    // Reversed endpoints, started on the first IDLE cycle after done.
    run_span("reversed", 11'd19, 11'd10, 11'd2, 32'd200, 32'd100,
             32'h1000_0000, 32'h2000_0000, 4'd12, 3, 7);
    chk("reversed_dx_const", cap_dx, 32'd10);
    chk("reversed_slope_const", cap_slope, 32'd10);
    chk("reversed_fb_const", cap_fb, 32'h1000_2028);
    chk("reversed_zs_const", cap_zs, 32'd100);

    // Negative slope
    run_span("negslope", 11'd0, 11'd3, 11'd0, 32'd100, 32'd90,
             32'h0, 32'h0, 4'd0, 1, 4);
    chk("negslope_dx_const", cap_dx, 32'd4);
    chk("negslope_slope_const", cap_slope, 32'hFFFF_FFFE);
    chk("negslope_rem_const", cap_rem, 32'd2);
    chk("negslope_zs_const", cap_zs, 32'd100);

    // Single pixel
    run_span("single", 11'd5, 11'd5, 11'd1, 32'd7, 32'd7,
             32'h0000_8000, 32'h0001_0000, 4'd8, 1, 1);
    chk("single_dx_const", cap_dx, 32'd1);
    chk("single_slope_const", cap_slope, 32'd0);
    chk("single_rem_const", cap_rem, 32'd0);

    // Boundaries: full-width span and the most negative depth delta.
    run_span("fullwidth", 11'd2047, 11'd0, 11'd2047, 32'hFFFF_0000, 32'h0123_4567,
             32'hFFFF_FFF0, 32'h8000_0000, 4'd15, 2, 3);
    chk("fullwidth_dx_const", cap_dx, 32'd2048);
    run_span("dzmin", 11'd100, 11'd100, 11'd3, 32'd0, 32'h8000_0000,
             32'h0, 32'h0, 4'd2, 1, 2);
    chk("dzmin_slope_const", cap_slope, 32'h8000_0000);

    // Reset in the middle of DIV, then a normal span.
    reset_mid_div();
    run_span("after_reset", 11'd30, 11'd40, 11'd5, 32'd1000, 32'd0,
             32'h1000_0000, 32'h2000_0000, 4'd11, 2, 5);

    // Randomized spans
    for (int n = 0; n < 8; n++) begin
      rx1 = 11'($urandom_range(0, 2047));
      rx2 = (n % 3 == 0) ? 11'($urandom_range(0, 15)) : 11'($urandom_range(0, 2047));
      ry  = 11'($urandom_range(0, 2047));
      run_span($sformatf("rand%0d", n), rx1, rx2, ry, $urandom, $urandom,
               $urandom, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(1, 5), $urandom_range(1, 60));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hline_setup.md
HLINE_SETUP -- requirements
Module: hline_setup

Interface
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 start  in  1  span request; sampled only in IDLE.
REQ-004 x1, x2  in  11 each  unsigned span endpoints, pixels.
REQ-005 y  in  11  unsigned scanline.
REQ-006 z1, z2  in  32 each  signed depths at x1 and x2.
REQ-007 fb_base, zbuff_base  in  32 each  byte base addresses.
REQ-008 stride_log2  in  4  log2 of line pitch in bytes.
REQ-009 hl_done  in  1  level "done" from the downstream hline z-buffer engine.
REQ-010 hl_start  out  1  one-cycle start pulse to the downstream engine.
REQ-011 fb_addr, zbuff_addr, dx, slope, z_start, rem, err  out  32 each  span parameters to the downstream engine.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse when the downstream span completes.

Function
REQ-014 States: IDLE, SETUP, DIV, FIX, ISSUE, WAIT_LO, WAIT_HI, DONE.
REQ-015 IDLE: on start=1, latch all inputs and go to SETUP; start in any other state is ignored.
REQ-016 SETUP: if x2<x1, swap (x1,z1) with (x2,z2).
REQ-017 SETUP: dx=x2-x1+1 (range 1..2048); dz=z2-z1 (32-bit two's complement, wraps silently).
REQ-018 SETUP: fb_addr=fb_base+(y<<stride_log2)+(x1<<2); zbuff_addr uses zbuff_base the same way; sums mod 2^32.
REQ-019 SETUP: z_start=z1 (after swap); err=0; go to DIV.
REQ-020 DIV: unsigned restoring divide of |dz| by dx, one quotient bit per cycle, exactly 32 cycles, then go to FIX.
REQ-021 FIX: slope = quotient, negated if dz<0 (truncate toward zero); rem = unsigned remainder; go to ISSUE.
REQ-022 dx is never 0, so there is no divide-by-zero path.
REQ-023 ISSUE: hl_start=1 for exactly one cycle; go to WAIT_LO.
REQ-024 hl_start is asserted during the 35th cycle after the edge that sampled start.
REQ-025 WAIT_LO: wait for hl_done=0, which discards the stale done from the previous span, then go to WAIT_HI.
REQ-026 WAIT_HI: wait for hl_done=1, then go to DONE.
REQ-027 DONE: done=1 for one cycle; go to IDLE. A start on the following IDLE cycle is accepted.
REQ-028 Parameter outputs are registered and hold stable from FIX until the next SETUP.

Reset
REQ-029 Reset forces state IDLE; all outputs 0; divider cleared.
REQ-030 Reset is effective mid-operation, including DIV and WAIT_HI; no pulse is emitted on reset release.

Structure
REQ-031 Shared package hline_pkg holds:
- the state encoding (4-bit);
- constant DIV_CYCLES=32;
- coordinate width 11;
- BYTES_PER_PIXEL=4.
REQ-032 The divider is sub-module hline_div (start/busy/valid, 32-bit dividend, 12-bit divisor, quotient and remainder outputs).

Verification
REQ-033 Basic span:
- stimulus: x1=10, x2=19, z1=100, z2=200, y=2, stride_log2=12, fb_base=0x1000_0000;
- response: dx=10, slope=10, rem=0, fb_addr=0x1000_2028, hl_start in cycle 35.
REQ-034 Reversed endpoints:
- stimulus: x1=19, x2=10, z1=200, z2=100;
- response: identical outputs to REQ-033.
REQ-035 Negative slope:
- stimulus: x1=0, x2=3, z1=100, z2=90;
- response: dx=4, slope=-2, rem=2, z_start=100.
REQ-036 Single pixel:
- stimulus: x1=x2=5, z1=7, z2=7;
- response: dx=1, slope=0, rem=0.
REQ-037 Handshake:
- stimulus: hl_done held 1 before issue, drops 2 cycles after hl_start, rises 50 cycles later;
- response: done pulses exactly once, one cycle after the rise;
- stimulus: start pulsed while busy;
- response: ignored.
REQ-038 Reset at cycle 20 of DIV:
- response: outputs 0 immediately, no hl_start;
- next start completes normally.
